// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM states for the UART transmit controller.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [31:0] UART_DATA_ADDR = 32'hFFFF_FFFC;
    localparam logic [31:0] UART_STAT_ADDR = 32'hFFFF_FFF0;

    localparam int STAT_EMPTY  = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_LVL_LO = 8;

    localparam int OVF_CLR_BIT = 3;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with occupancy count.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module uart_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == LW'(DEPTH));
    assign level   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next pointers and occupancy from the accepted push/pop pair.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) wptr_d = wptr_q + AW'(1);
        if (pop_ok)  rptr_d = rptr_q + AW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset discards queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array needs no reset; occupancy guards its contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped UART transmitter with FIFO and 8N1 serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [31:0] DATA_ADDR    = UART_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR    = UART_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wEn,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    output logic        sel,
    output logic        txd,
    output logic        busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int LW = $clog2(DEPTH) + 1;

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          ovf_q, ovf_d;

    logic          hit_data;
    logic          hit_stat;
    logic          push;
    logic          pop;
    logic          cnt_last;
    logic [7:0]    f_rdata;
    logic          f_full;
    logic          f_empty;
    logic [LW-1:0] f_level;
    logic [31:0]   stat;
    logic          unused_wdata;

    assign unused_wdata = ^{wData[31:8]};

    assign hit_data = (addr == DATA_ADDR);
    assign hit_stat = (addr == STAT_ADDR);
    assign sel      = hit_data || hit_stat;
    assign push     = wEn && hit_data;
    assign cnt_last = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign busy     = (state_q != ST_IDLE) || !f_empty;

    uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wData[7:0]),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty),
        .level (f_level)
    );

    // Sticky overflow: a dropped byte sets it, a control write clears it.
    always_comb begin
        ovf_d = ovf_q;
        if (wEn && hit_stat && wData[OVF_CLR_BIT]) ovf_d = 1'b0;
        if (push && f_full && !pop)                ovf_d = 1'b1;
    end

    // Status word, visible only when the status address is on the bus.
    always_comb begin
        stat                    = '0;
        stat[STAT_EMPTY]        = f_empty;
        stat[STAT_FULL]         = f_full;
        stat[STAT_BUSY]         = busy;
        stat[STAT_OVF]          = ovf_q;
        stat[STAT_LVL_LO +: 8]  = 8'(f_level);
        rData                   = hit_stat ? stat : 32'h0;
    end

    // Serializer: START, 8 data bits LSB first, optional parity, STOP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!f_empty) begin
                    pop     = 1'b1;
                    sh_d    = f_rdata;
                    par_d   = even_parity(f_rdata);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!f_empty) begin
                        pop     = 1'b1;
                        sh_d    = f_rdata;
                        par_d   = even_parity(f_rdata);
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the serializer state directly.
    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            ST_START:  txd = 1'b0;
            ST_DATA:   txd = sh_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd = par_q;
`endif
            default:   txd = 1'b1;
        endcase
    end

    // Serializer and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
